// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing defaults, derived boundaries and a small window-compare helper.
package vga_timing_pkg;

    localparam int unsigned CNT_W         = 10;
    localparam int unsigned DIV_W         = 4;

    localparam int unsigned CLK_DIV_DEF   = 4;
    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL_DEF  = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int unsigned HS_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int unsigned HS_END_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF - 1;
    localparam int unsigned VS_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int unsigned VS_END_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF - 1;

    // True when lo <= v <= hi, all compared at full counter width.
    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable. carry is high when an enabled step wraps N-1 -> 0,
// so counters can be chained; count_next exposes the value the register takes next.
module mod_counter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count and wrap carry.
    always_comb begin
        count_d = count_q;
        carry   = 1'b0;
        if (en) begin
            if (count_q == LAST) begin
                count_d = {W{1'b0}};
                carry   = 1'b1;
            end else begin
                count_d = count_q + W'(1);
                carry   = 1'b0;
            end
        end else begin
            count_d = count_q;
            carry   = 1'b0;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate strobe, x/y counters and registered sync/blanking/frame
// outputs decoded from the next counter values so they stay aligned with pixel_x/pixel_y.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             frame_tick
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_unused;
    logic [DIV_W-1:0] div_next_unused;
    logic             p_tick_s;
    logic [CNT_W-1:0] x_s, x_next_s, y_s, y_next_s;
    logic             x_carry_s, y_carry_s;

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic video_on_q, video_on_d;
    logic frame_tick_q, frame_tick_d;

    // Enabling the divider with reset forces p_tick low while reset is held (matters for CLK_DIV=1).
    mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
        .clk        (clk),
        .reset      (reset),
        .en         (reset),
        .count      (div_unused),
        .count_next (div_next_unused),
        .carry      (p_tick_s)
    );

    mod_counter #(.N(H_TOTAL), .W(CNT_W)) u_x (
        .clk        (clk),
        .reset      (reset),
        .en         (p_tick_s),
        .count      (x_s),
        .count_next (x_next_s),
        .carry      (x_carry_s)
    );

    mod_counter #(.N(V_TOTAL), .W(CNT_W)) u_y (
        .clk        (clk),
        .reset      (reset),
        .en         (x_carry_s),
        .count      (y_s),
        .count_next (y_next_s),
        .carry      (y_carry_s)
    );

    // Decode sync/blanking from the next coordinates; hold between pixel strobes so (0,0) stays blanked after reset.
    always_comb begin
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        video_on_d   = video_on_q;
        frame_tick_d = y_carry_s;
        if (p_tick_s) begin
            hsync_d    = !in_window(x_next_s, HS_START, HS_END);
            vsync_d    = !in_window(y_next_s, VS_START, VS_END);
            video_on_d = (x_next_s < H_VIS) && (y_next_s < V_VIS);
        end else begin
            hsync_d    = hsync_q;
            vsync_d    = vsync_q;
            video_on_d = video_on_q;
        end
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            video_on_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign p_tick     = p_tick_s;
    assign pixel_x    = x_s;
    assign pixel_y    = y_s;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three builds (default 640x480 /4, tiny /1, tiny /3) checked every
// clock against an arithmetic model of the timing, plus line/frame measurements and random resets.
module tb_vga_sync_gen;

    typedef struct {
        int d; int hd; int hf; int hs; int hb; int vd; int vf; int vs; int vb;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic pt_a, hs_a, vs_a, vo_a, ft_a;
    logic pt_b, hs_b, vs_b, vo_b, ft_b;
    logic pt_c, hs_c, vs_c, vo_c, ft_c;
    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;

    int n_assert = 0;
    int n_fail   = 0;
    int t_a, t_b, t_c;
    int cyc = 0;
    int phase = 0;
    int hs_low_a = 0, vo_low_a = 0;
    int last_ft_b = -1, last_ft_c = -1;
    int hold_a = 0, hold_b = 0, hold_c = 0;
    cfg_t cfg_a, cfg_b, cfg_c;

    vga_sync_gen #(.CLK_DIV(4)) dut_a (
        .clk(clk), .reset(rst_a), .p_tick(pt_a), .pixel_x(x_a), .pixel_y(y_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .frame_tick(ft_a)
    );

    vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)) dut_b (
        .clk(clk), .reset(rst_b), .p_tick(pt_b), .pixel_x(x_b), .pixel_y(y_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .frame_tick(ft_b)
    );

    vga_sync_gen #(.CLK_DIV(3), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
                   .V_DISPLAY(5), .V_FRONT(2), .V_SYNC(1), .V_BACK(3)) dut_c (
        .clk(clk), .reset(rst_c), .p_tick(pt_c), .pixel_x(x_c), .pixel_y(y_c),
        .hsync(hs_c), .vsync(vs_c), .video_on(vo_c), .frame_tick(ft_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Timing model: t = clock edges since the last reset edge, steps = pixel strobes consumed.
    task automatic chk_inst(input string nm, input cfg_t c, input int t, input logic rn,
                            input logic pt, input logic [9:0] x, input logic [9:0] y,
                            input logic hs, input logic vs, input logic vo, input logic ft);
        int ht, vt, steps, ex, ey;
        logic ept, ehs, evs, evo, eft;
        ht    = c.hd + c.hf + c.hs + c.hb;
        vt    = c.vd + c.vf + c.vs + c.vb;
        steps = t / c.d;
        ex    = steps % ht;
        ey    = (steps / ht) % vt;
        ept   = rn && ((t % c.d) == c.d - 1);
        if (steps == 0) begin
            ehs = 1'b1; evs = 1'b1; evo = 1'b0;
        end else begin
            ehs = !(ex >= c.hd + c.hf && ex < c.hd + c.hf + c.hs);
            evs = !(ey >= c.vd + c.vf && ey < c.vd + c.vf + c.vs);
            evo = (ex < c.hd) && (ey < c.vd);
        end
        eft = (steps > 0) && ((t % c.d) == 0) && ((steps % (ht * vt)) == 0);
        chk({nm, ".p_tick"},     32'(pt), 32'(ept));
        chk({nm, ".pixel_x"},    32'(x),  32'(ex));
        chk({nm, ".pixel_y"},    32'(y),  32'(ey));
        chk({nm, ".hsync"},      32'(hs), 32'(ehs));
        chk({nm, ".vsync"},      32'(vs), 32'(evs));
        chk({nm, ".video_on"},   32'(vo), 32'(evo));
        chk({nm, ".frame_tick"}, 32'(ft), 32'(eft));
    endtask

    // One clock: advance model at the edge, check all builds on the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst_a) t_a = 0; else t_a++;
        if (!rst_b) t_b = 0; else t_b++;
        if (!rst_c) t_c = 0; else t_c++;
        @(negedge clk);
        chk_inst("a", cfg_a, t_a, rst_a, pt_a, x_a, y_a, hs_a, vs_a, vo_a, ft_a);
        chk_inst("b", cfg_b, t_b, rst_b, pt_b, x_b, y_b, hs_b, vs_b, vo_b, ft_b);
        chk_inst("c", cfg_c, t_c, rst_c, pt_c, x_c, y_c, hs_c, vs_c, vo_c, ft_c);
        if (phase == 2 && y_a == 10'd1) begin
            if (!hs_a) hs_low_a++;
            if (!vo_a) vo_low_a++;
        end
        if (!rst_b) last_ft_b = -1;
        else if (ft_b) begin
            if (last_ft_b >= 0) chk("b.frame_period", 32'(cyc - last_ft_b), 32'(165));
            last_ft_b = cyc;
        end
        if (!rst_c) last_ft_c = -1;
        else if (ft_c) begin
            if (last_ft_c >= 0) chk("c.frame_period", 32'(cyc - last_ft_c), 32'(627));
            last_ft_c = cyc;
        end
    endtask

    initial begin
        cfg_a = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
        cfg_b = '{1, 8, 2, 3, 2, 6, 1, 2, 2};
        cfg_c = '{3, 10, 2, 4, 3, 5, 2, 1, 3};
        t_a = 0; t_b = 0; t_c = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Hold reset for 10 clocks.
        phase = 1;
        for (int i = 0; i < 10; i++) step();

        // Free-run: default build passes line 10 -> 11 wrap; tiny builds run many frames.
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        phase = 2;
        for (int i = 0; i < 36000; i++) step();
        chk("a.hsync_low_clks_line1", 32'(hs_low_a), 32'(384));
        chk("a.blank_clks_line1",     32'(vo_low_a), 32'(640));

        // Random short resets landing mid-line / mid-frame.
        phase = 3;
        for (int i = 0; i < 4000; i++) begin
            if (hold_a > 0) begin hold_a--; rst_a = 1'b0; end
            else if ($urandom_range(0, 499) == 0) begin hold_a = $urandom_range(0, 2); rst_a = 1'b0; end
            else rst_a = 1'b1;
            if (hold_b > 0) begin hold_b--; rst_b = 1'b0; end
            else if ($urandom_range(0, 199) == 0) begin hold_b = $urandom_range(0, 2); rst_b = 1'b0; end
            else rst_b = 1'b1;
            if (hold_c > 0) begin hold_c--; rst_c = 1'b0; end
            else if ($urandom_range(0, 299) == 0) begin hold_c = $urandom_range(0, 2); rst_c = 1'b0; end
            else rst_c = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
